// File: rtl/setting_feeder.sv
// Root-side initiator for the distributor/nlfsr_tester tree.
// Issues a setting range into the tree and collects successful settings.
module setting_feeder #(
  parameter int SETTING_WIDTH = 27,
  parameter int RES_DEPTH     = 4,
  parameter int DRAIN_CYCLES  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_start,
  input  logic                     cmd_abort,
  input  logic [SETTING_WIDTH-1:0] range_lo,
  input  logic [SETTING_WIDTH-1:0] range_hi,
  output logic                     busy,
  output logic                     done,
  output logic [SETTING_WIDTH:0]   issued_count,
  output logic [31:0]              found_count,
  output logic                     tree_start,
  output logic [SETTING_WIDTH-1:0] tree_setting,
  input  logic                     tree_idle,
  input  logic                     tree_running,
  input  logic                     tree_success,
  input  logic [SETTING_WIDTH-1:0] tree_setting_out,
  output logic                     tree_setting_rd_en,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [SETTING_WIDTH-1:0] res_setting
);

  localparam int W  = SETTING_WIDTH;
  localparam int AW = $clog2(RES_DEPTH);
  localparam int QW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   cur_q, hi_q;
  logic [W:0]     issued_q;
  logic [31:0]    found_q, found_base;
  logic [QW-1:0]  quiet_q;
  logic           done_q;
  logic [W-1:0]   mem [RES_DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [AW:0]    cnt_q;

  logic accept, abort, quiet, quiet_hit, finish;
  logic fifo_full, push, pop;

  assign accept    = (state_q == IDLE) & cmd_start & ~cmd_abort;
  assign abort     = (state_q != IDLE) & cmd_abort;
  assign quiet     = tree_idle & ~tree_running & ~tree_success;
  assign quiet_hit = quiet & (quiet_q == QW'(DRAIN_CYCLES - 1));
  assign fifo_full = (cnt_q == (AW+1)'(RES_DEPTH));

  // An abort cycle never issues, so the issued count freezes cleanly.
  assign tree_start = (state_q == ISSUE) & tree_idle & ~cmd_abort;
  assign tree_setting_rd_en = tree_success & ~fifo_full;
  assign push = tree_setting_rd_en;
  assign pop  = res_valid & res_ready;

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign issued_count = issued_q;
  assign found_count  = found_q;
  assign tree_setting = cur_q;
  assign res_valid    = (cnt_q != '0);
  assign res_setting  = res_valid ? mem[rd_q] : '0;

  always_comb begin
    state_d = state_q;
    finish  = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept)
            state_d = (range_lo > range_hi) ? DRAIN : ISSUE;
        end
        ISSUE: begin
          if (tree_start && (cur_q == hi_q))
            state_d = DRAIN;
        end
        DRAIN: begin
          if (quiet_hit) begin
            state_d = IDLE;
            finish  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign found_base = accept ? 32'd0 : found_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      hi_q     <= '0;
      issued_q <= '0;
      found_q  <= '0;
      quiet_q  <= '0;
      done_q   <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= finish;

      // Compare before increment so hi = all-ones never wraps.
      if (accept) begin
        cur_q    <= range_lo;
        hi_q     <= range_hi;
        issued_q <= '0;
      end else if (tree_start) begin
        issued_q <= issued_q + (W+1)'(1);
        if (cur_q != hi_q)
          cur_q <= cur_q + W'(1);
      end

      if ((state_q == DRAIN) && quiet && !quiet_hit && !abort)
        quiet_q <= quiet_q + QW'(1);
      else
        quiet_q <= '0;

      if (push && (found_base != 32'hFFFF_FFFF))
        found_q <= found_base + 32'd1;
      else
        found_q <= found_base;

      if (push)
        wr_q <= wr_q + AW'(1);
      if (pop)
        rd_q <= rd_q + AW'(1);

      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_q] <= tree_setting_out;
  end

endmodule

// File: doc/setting_feeder.md
Name: setting_feeder

Overview:
- Root-side initiator for the distributor/nlfsr_tester tree.
- Enumerates a contiguous range of candidate settings and issues each one into the tree's start/setting_in port whenever the tree root reports idle.
- Drains successful settings out of the tree via the success/setting_rd_en handshake into a small result FIFO.
- Signals completion once the whole range has been issued and the tree has gone quiet.

Parameters:
SETTING_WIDTH, 27, width of one setting word; must match the tree instance.
RES_DEPTH, 4, result FIFO depth; power of two, at least 2.
DRAIN_CYCLES, 16, consecutive quiet cycles required before done; must exceed the tree's worst-case status propagation latency.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_start  in  1  pulse; latch range and begin a search (ignored while busy)
cmd_abort  in  1  stop issuing; return to idle without done
range_lo  in  SETTING_WIDTH  first setting, sampled on accepted cmd_start
range_hi  in  SETTING_WIDTH  last setting inclusive, sampled on accepted cmd_start
busy  out  1  high from accepted cmd_start until done/abort
done  out  1  one-cycle pulse at search completion
issued_count  out  SETTING_WIDTH+1  settings issued in current search
found_count  out  32  results captured in current search, saturating
tree_start  out  1  to tree root start
tree_setting  out  SETTING_WIDTH  to tree root setting_in
tree_idle  in  1  from tree root idle
tree_running  in  1  from tree root running
tree_success  in  1  from tree root success
tree_setting_out  in  SETTING_WIDTH  from tree root setting_out
tree_setting_rd_en  out  1  to tree root setting_rd_en
res_valid  out  1  FIFO non-empty
res_ready  in  1  consumer accepts head
res_setting  out  SETTING_WIDTH  FIFO head

Behaviour:
- Reset: state IDLE; busy=0, done=0, tree_start=0, tree_setting=0, tree_setting_rd_en=0; issued_count=0, found_count=0; FIFO empty, res_valid=0, res_setting=0. Reset mid-search discards everything. Tree state is not reset by this block.
- States: IDLE, ISSUE, DRAIN.
- IDLE: on cmd_start, latch cur=range_lo, hi=range_hi, clear both counters, busy=1.
  - If range_lo>range_hi, go to DRAIN with nothing issued; otherwise go to ISSUE.
- ISSUE: tree_start = tree_idle (combinational, state-qualified); tree_setting = cur (registered, holds during ISSUE).
  - Each cycle with tree_start=1: issued_count+1. If cur==hi, go to DRAIN; else cur+1 and stay in ISSUE.
  - Back-to-back starts are legal: the root drops idle in the cycle after it samples start, so a second start is only issued once idle returns.
  - cur must never wrap. Comparison against hi happens before increment, so hi = all-ones terminates correctly.
- DRAIN: quiet counter increments while tree_idle=1 and tree_running=0 and tree_success=0; any other cycle clears it.
  - On reaching DRAIN_CYCLES: done=1 for one cycle, busy=0, state IDLE.
- cmd_abort (any state except IDLE): next state IDLE, busy=0, no done pulse, counters hold.
  - cmd_abort has priority over cmd_start and over ISSUE/DRAIN transitions.
- Result collection runs in every state, including IDLE after abort:
  - tree_setting_rd_en = tree_success & ~fifo_full (combinational). tree_setting_out is pushed into the FIFO in the same cycle.
  - The tree clears success one cycle after rd_en, so no double push occurs.
  - When the FIFO is full, success is left pending in the tree (backpressure); the tree then stays non-quiet and done is deferred.
- found_count increments on each push and saturates at 2^32-1.
- FIFO: first-word fall-through; res_setting = head.
  - Pop on res_valid & res_ready.
  - Simultaneous push and pop when non-empty is allowed with count unchanged.
  - When full, a same-cycle pop does not enable a push (no bypass).
- cmd_start while busy: ignored; latched range and counters are unchanged.

Test Plan:
- Range 5..8, tree idle permanently high, no success → tree_start high 4 cycles with tree_setting 5,6,7,8; issued_count=4; done exactly DRAIN_CYCLES cycles after entering DRAIN.
- Tree model drops idle for 3 cycles after each start, range 0..2 → 3 starts spaced by the idle gaps, never a start while idle=0; busy falls with done.
- Tree model reports success with setting_out=0x1234567 twice, res_ready=1 → one rd_en pulse per success; res_setting 0x1234567 twice; found_count=2.
- res_ready=0, tree reports 6 successes, RES_DEPTH=4 → exactly 4 pushes; rd_en held off with success pending; done not asserted; raising res_ready drains the remaining 2, then done.
- range_lo=9, range_hi=3 → no tree_start; issued_count=0; done after DRAIN_CYCLES quiet cycles.
- cmd_abort in the third ISSUE cycle of range 0..100 → busy=0 next cycle, no done, issued_count frozen; a later success is still captured. rst mid-search → all outputs return to reset values next cycle.
